// File: rtl/mem_arbiter_2to1_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter_2to1_pkg                                                        |
// | Memory message types and arbiter constants shared by the 2:1 arbiter.       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package mem_arbiter_2to1_pkg;

    localparam int MEM_OPAQ_BITS = 8;
    localparam int ARB_NUM_PORTS = 2;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_AMO   = 2'd2
    } t_op;

    typedef logic [$clog2(ARB_NUM_PORTS)-1:0] arb_id_t;

    typedef struct packed {
        t_op                      op;
        logic [MEM_OPAQ_BITS-1:0] opaque;
        logic [31:0]              addr;
        logic [3:0]               strb;
        logic [31:0]              data;
    } mem_req_t;

    typedef struct packed {
        t_op                      op;
        logic [MEM_OPAQ_BITS-1:0] opaque;
        logic [31:0]              data;
    } mem_resp_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_id_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arb_id_fifo                                                             |
// | In-order FIFO of requester IDs; the head steers the next memory response.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module mem_arb_id_fifo
    import mem_arbiter_2to1_pkg::*;
#(
    parameter int p_depth = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push_i,
    input  logic    pop_i,
    input  arb_id_t id_i,
    output logic    full_o,
    output logic    empty_o,
    output arb_id_t head_o
);

    localparam int               PTR_W    = $clog2(p_depth);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(p_depth);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    arb_id_t [p_depth-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = id_i;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/mem_arbiter_2to1.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter_2to1                                                            |
// | Round-robin 2:1 memory request arbiter with in-order response routing.      |
// | Define MEM_ARB_FIXED_PRIORITY_EN for fixed priority (port 0 always wins).   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module mem_arbiter_2to1
    import mem_arbiter_2to1_pkg::*;
#(
    parameter int p_opaq_bits     = MEM_OPAQ_BITS,
    parameter int p_max_in_flight = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      req0_val,
    output logic      req0_rdy,
    input  mem_req_t  req0_msg,
    output logic      resp0_val,
    input  logic      resp0_rdy,
    output mem_resp_t resp0_msg,
    input  logic      req1_val,
    output logic      req1_rdy,
    input  mem_req_t  req1_msg,
    output logic      resp1_val,
    input  logic      resp1_rdy,
    output mem_resp_t resp1_msg,
    output logic      mem_req_val,
    input  logic      mem_req_rdy,
    output mem_req_t  mem_req_msg,
    input  logic      mem_resp_val,
    output logic      mem_resp_rdy,
    input  mem_resp_t mem_resp_msg
);

    localparam arb_id_t ID0 = arb_id_t'(0);
    localparam arb_id_t ID1 = arb_id_t'(1);

    generate
        if (p_opaq_bits != MEM_OPAQ_BITS) begin : g_opaq_chk
            $error("p_opaq_bits must match MEM_OPAQ_BITS in mem_arbiter_2to1_pkg");
        end
        if (p_max_in_flight < 2 || (p_max_in_flight & (p_max_in_flight - 1)) != 0) begin : g_depth_chk
            $error("p_max_in_flight must be a power of two and at least 2");
        end
    endgenerate

    arb_id_t grant_id;
    arb_id_t head;
    logic    grant_valid;
    logic    full;
    logic    empty;
    logic    issue;
    logic    pop;
    logic    resp_rdy_of_head;

`ifdef MEM_ARB_FIXED_PRIORITY_EN
    always_comb begin
        grant_id = req0_val ? ID0 : ID1;
    end
`else
    arb_id_t last_grant_q, last_grant_d;

    always_comb begin
        if (req0_val && req1_val) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = req1_val ? ID1 : ID0;
        end
        last_grant_d = issue ? grant_id : last_grant_q;
    end

    // Reset to 1 so port 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= ID1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    // Full blocks the grant even when a pop is pending: no response-to-request path.
    assign grant_valid = !full && (req0_val || req1_val);
    assign mem_req_val = grant_valid;
    assign mem_req_msg = (grant_id == ID1) ? req1_msg : req0_msg;
    assign req0_rdy    = grant_valid && (grant_id == ID0) && mem_req_rdy;
    assign req1_rdy    = grant_valid && (grant_id == ID1) && mem_req_rdy;
    assign issue       = grant_valid && mem_req_rdy;

    assign resp_rdy_of_head = (head == ID1) ? resp1_rdy : resp0_rdy;
    assign mem_resp_rdy     = !empty && resp_rdy_of_head;
    assign resp0_val        = mem_resp_val && !empty && (head == ID0);
    assign resp1_val        = mem_resp_val && !empty && (head == ID1);
    assign resp0_msg        = mem_resp_msg;
    assign resp1_msg        = mem_resp_msg;
    assign pop              = mem_resp_val && mem_resp_rdy;

    mem_arb_id_fifo #(
        .p_depth (p_max_in_flight)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (issue),
        .pop_i   (pop),
        .id_i    (grant_id),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(mem_resp_val && empty))
                else $error("mem_arbiter_2to1: memory response with nothing outstanding");
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/mem_arbiter_2to1.md
Name: mem_arbiter_2to1

Overview:
- Shares one memory client port between two requesters: port 0 is the fetch unit, port 1 is the load/store unit.
- Issue path: round-robin arbitration of valid requests onto the single memory request channel, combinational pass-through, zero added latency.
- Return path: records the granted requester ID in an in-order tracking FIFO and uses the FIFO head to route each memory response back to its requester.
- Sits between the pipeline's memory clients and the memory/cache interface.

Parameters:
- p_opaq_bits, 8, width of the opaque field in memory messages (passed through unmodified).
- p_max_in_flight, 4, maximum outstanding requests; tracking FIFO depth; power of two, >=2.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- req0_val / req0_rdy  input/output  1/1  requester 0 request handshake
- req0_msg  input  $bits(mem_req_t)  requester 0 request (op, opaque, addr[31:0], strb[3:0], data[31:0])
- resp0_val / resp0_rdy  output/input  1/1  requester 0 response handshake
- resp0_msg  output  $bits(mem_resp_t)  requester 0 response
- req1_val, req1_rdy, req1_msg, resp1_val, resp1_rdy, resp1_msg: same widths and meanings, for requester 1.
- mem_req_val / mem_req_rdy  output/input  1/1  downstream request handshake
- mem_req_msg  output  $bits(mem_req_t)  muxed request
- mem_resp_val / mem_resp_rdy  input/output  1/1  downstream response handshake
- mem_resp_msg  input  $bits(mem_resp_t)  downstream response

Behaviour:
- Clocking and reset: single clock; all state resets synchronously when rst=1.
- Reset values: FIFO empty, count=0, last_grant=1 (so port 0 wins the first contention). All val/rdy outputs are 0 during and immediately after reset until inputs assert.
- Arbitration (combinational):
  - If the FIFO is full (count==p_max_in_flight), no grant is made; req0_rdy=req1_rdy=0 and mem_req_val=0.
  - Otherwise the grant goes to the sole valid requester. If both are valid, it goes to the port != last_grant.
  - grant_id selects mem_req_msg.
  - mem_req_val = grant_valid.
  - reqN_rdy = (grant_id==N) & grant_valid & mem_req_rdy. The non-granted port's rdy is 0.
  - mem_req_val must not depend on mem_req_rdy.
- Issue transfer: when mem_req_val & mem_req_rdy:
  - push grant_id into the FIFO;
  - last_grant <= grant_id.
  - last_grant changes only on an issue transfer.
- Full condition: full blocks a grant even if a pop occurs in the same cycle. This is deliberate: it removes the combinational path from response to request.
- Response routing:
  - Memory returns responses in issue order; this is an interface requirement on downstream.
  - head = FIFO head ID.
  - resp_head_val = mem_resp_val & !empty; respN_val = resp_head_val & (head==N).
  - mem_resp_rdy = !empty & resp_rdy_of_head.
  - Both respN_msg outputs carry mem_resp_msg unmodified.
- Pop: on mem_resp_val & mem_resp_rdy, the FIFO pops.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- Pointers wrap modulo p_max_in_flight. Count width is $clog2(p_max_in_flight)+1.
- Spurious response: mem_resp_val while empty is ignored (mem_resp_rdy=0). In simulation, assertion fires.
- Reset mid-operation: outstanding IDs are discarded. Downstream must be reset in the same cycle.
- Latency: request path 0 cycles; response path 0 cycles.

Optional Feature:
- MEM_ARB_FIXED_PRIORITY_EN
- Defined: port 0 always wins contention; last_grant is removed and round-robin is disabled. Fetch can then starve load/store, which is acceptable for bring-up only.
- Undefined: round-robin as specified above.

Decomposition:
- Shared package (UArch):
  - mem_req_t and mem_resp_t packed structs parameterized on p_opaq_bits; if already present with the memory interface definitions, reuse them.
  - t_op enum.
  - localparam ARB_NUM_PORTS=2.
- One sub-module: mem_arb_id_fifo, a synchronous FIFO of 1-bit IDs with depth p_max_in_flight, exposing push, pop, full, empty and head.

Test Plan:
- Only req0 valid, addr 0x100, mem_req_rdy=1, response returned next cycle -> mem_req_msg.addr=0x100 in cycle 0; resp0_val=1 with data 0xDEADBEEF; resp1_val stays 0.
- Both ports valid for 4 cycles, mem always ready -> grant order 0,1,0,1; responses route back in that order.
- mem_req_rdy=1, no responses; issue 4 requests -> 5th cycle req0_rdy=req1_rdy=0 and mem_req_val=0. Return one response -> next cycle grant resumes.
- resp0_rdy=0 while head ID=0 and mem_resp_val=1 -> mem_resp_rdy=0 and the FIFO holds. Raise resp0_rdy -> pop and deliver.
- With 2 outstanding, push and pop in the same cycle for 10 cycles -> count stays 2 and pointers wrap correctly.
- rst asserted with 3 outstanding -> next cycle empty, mem_resp_rdy=0, and port 0 wins the first contention.
